// File: rtl/mtsp_dst_pkg.sv
// Shared types, constants and lane classifier for the 4-lane destination write-back pipeline.
package mtsp_dst_pkg;

  typedef enum logic [1:0] {
    DSTOP_NONE   = 2'b00,
    DSTOP_SAT01  = 2'b01,
    DSTOP_SATN11 = 2'b10,
    DSTOP_RSVD   = 2'b11
  } dstop_t;

  localparam logic [31:0] FP_ONE     = 32'h3F800000;
  localparam logic [31:0] FP_NEG_ONE = 32'hBF800000;
  localparam int unsigned LANES      = 4;

  typedef struct packed {
    logic nan;
    logic sign;
    logic gt_one;
  } lane_flag_t;

  // gt_one compares magnitude bits only, so +/-inf and NaN both report it
  function automatic lane_flag_t classify(input logic [31:0] x);
    lane_flag_t f;
    f.nan    = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    f.sign   = x[31];
    f.gt_one = x[30:0] > FP_ONE[30:0];
    return f;
  endfunction

endpackage

// File: rtl/mtsp_dst_writeback_4d_if.sv
// Result-in / write-beat-out handshake bundle for mtsp_dst_writeback_4d.
interface mtsp_dst_writeback_4d_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              in_vld;
  logic              in_rdy;
  logic [1:0]        in_op;
  logic [3:0]        in_mask;
  logic [ADDR_W-1:0] in_addr;
  logic [127:0]      in_dat;

  logic              out_vld;
  logic              out_rdy;
  logic [3:0]        out_we;
  logic [ADDR_W-1:0] out_addr;
  logic [127:0]      out_dat;

  modport slave (
    input  in_vld, in_op, in_mask, in_addr, in_dat,
    output in_rdy,
    output out_vld, out_we, out_addr, out_dat,
    input  out_rdy
  );

  modport master (
    output in_vld, in_op, in_mask, in_addr, in_dat,
    input  in_rdy,
    input  out_vld, out_we, out_addr, out_dat,
    output out_rdy
  );
endinterface

// File: rtl/mtsp_dst_operate_1d.sv
// One float lane: classifies the raw input and selects the clamped result from registered flags.
// Built only with MTSP_DSTOP_SATURATE_EN; otherwise a bit-exact pass-through.
module mtsp_dst_operate_1d
  import mtsp_dst_pkg::*;
(
`ifdef MTSP_DSTOP_SATURATE_EN
  input  logic [31:0] raw_dat,
  output lane_flag_t  raw_flags,
  input  dstop_t      op,
  input  lane_flag_t  flags,
  output logic        clamped,
`endif
  input  logic [31:0] dat,
  output logic [31:0] res_dat
);

`ifdef MTSP_DSTOP_SATURATE_EN
  assign raw_flags = classify(raw_dat);

  always_comb begin
    res_dat = dat;
    case (op)
      DSTOP_SAT01: begin
        if (flags.nan || flags.sign) begin
          res_dat = 32'h0000_0000;
        end else if (flags.gt_one) begin
          res_dat = FP_ONE;
        end
      end
      DSTOP_SATN11: begin
        // -0 and in-range negatives keep their sign bit untouched
        if (flags.nan) begin
          res_dat = 32'h0000_0000;
        end else if (flags.gt_one) begin
          res_dat = flags.sign ? FP_NEG_ONE : FP_ONE;
        end
      end
      default: res_dat = dat;
    endcase
  end

  assign clamped = (res_dat != dat);
`else
  assign res_dat = dat;
`endif

endmodule

// File: rtl/mtsp_dst_writeback_4d.sv
// 2-stage valid/ready destination modifier + write mask, 1-cycle latency past accept, full-rate with stall.
// Saturation and CLAMP_CNT exist only when MTSP_DSTOP_SATURATE_EN is defined.
module mtsp_dst_writeback_4d
  import mtsp_dst_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  mtsp_dst_writeback_4d_if.slave  bus,
  input  logic                    cnt_clr,
  output logic                    busy,
  output logic [15:0]             clamp_cnt
);

  logic              b_adv, a_adv, accept, b_load;
  logic              a_vld_q, a_vld_d;
  logic [3:0]        a_mask_q, a_mask_d;
  logic [ADDR_W-1:0] a_addr_q, a_addr_d;
  logic [127:0]      a_dat_q, a_dat_d;
  logic              out_vld_q, out_vld_d;
  logic [3:0]        out_we_q, out_we_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [127:0]      out_dat_q, out_dat_d;
  logic [127:0]      res_dat;

`ifdef MTSP_DSTOP_SATURATE_EN
  dstop_t                 a_op_q, a_op_d;
  lane_flag_t [LANES-1:0] a_flags_q, a_flags_d, raw_flags;
  logic [LANES-1:0]       lane_clamped;
  logic [15:0]            cnt_q, cnt_d;
`endif

  assign b_adv  = !out_vld_q || bus.out_rdy;
  assign a_adv  = !a_vld_q || b_adv;
  assign accept = bus.in_vld && a_adv;
  // a zero-mask beat occupies stage A for one slot and is then dropped
  assign b_load = a_vld_q && b_adv && (a_mask_q != 4'b0000);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    mtsp_dst_operate_1d u_operate (
`ifdef MTSP_DSTOP_SATURATE_EN
      .raw_dat   (bus.in_dat[32*i +: 32]),
      .raw_flags (raw_flags[i]),
      .op        (a_op_q),
      .flags     (a_flags_q[i]),
      .clamped   (lane_clamped[i]),
`endif
      .dat       (a_dat_q[32*i +: 32]),
      .res_dat   (res_dat[32*i +: 32])
    );
  end

  always_comb begin
    a_vld_d    = a_vld_q;
    a_mask_d   = a_mask_q;
    a_addr_d   = a_addr_q;
    a_dat_d    = a_dat_q;
    out_vld_d  = out_vld_q;
    out_we_d   = out_we_q;
    out_addr_d = out_addr_q;
    out_dat_d  = out_dat_q;

    if (a_adv) begin
      a_vld_d = bus.in_vld;
    end
    if (accept) begin
      a_mask_d = bus.in_mask;
      a_addr_d = bus.in_addr;
      a_dat_d  = bus.in_dat;
    end

    if (b_adv) begin
      out_vld_d = b_load;
    end
    if (b_load) begin
      out_we_d   = a_mask_q;
      out_addr_d = a_addr_q;
      out_dat_d  = res_dat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_vld_q    <= 1'b0;
      a_mask_q   <= '0;
      a_addr_q   <= '0;
      a_dat_q    <= '0;
      out_vld_q  <= 1'b0;
      out_we_q   <= '0;
      out_addr_q <= '0;
      out_dat_q  <= '0;
    end else begin
      a_vld_q    <= a_vld_d;
      a_mask_q   <= a_mask_d;
      a_addr_q   <= a_addr_d;
      a_dat_q    <= a_dat_d;
      out_vld_q  <= out_vld_d;
      out_we_q   <= out_we_d;
      out_addr_q <= out_addr_d;
      out_dat_q  <= out_dat_d;
    end
  end

`ifdef MTSP_DSTOP_SATURATE_EN
  always_comb begin
    a_op_d    = a_op_q;
    a_flags_d = a_flags_q;
    if (accept) begin
      a_op_d    = dstop_t'(bus.in_op);
      a_flags_d = raw_flags;
    end

    // clear has priority over a coinciding increment
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (b_load && ((lane_clamped & a_mask_q) != 4'b0000) && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_op_q    <= DSTOP_NONE;
      a_flags_q <= '0;
      cnt_q     <= '0;
    end else begin
      a_op_q    <= a_op_d;
      a_flags_q <= a_flags_d;
      cnt_q     <= cnt_d;
    end
  end

  assign clamp_cnt = cnt_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{bus.in_op, cnt_clr};
  assign clamp_cnt  = 16'd0;
`endif

  assign bus.in_rdy   = a_adv;
  assign bus.out_vld  = out_vld_q;
  assign bus.out_we   = out_we_q;
  assign bus.out_addr = out_addr_q;
  assign bus.out_dat  = out_dat_q;
  assign busy         = a_vld_q || out_vld_q;

endmodule

// File: tb/tb_mtsp_dst_writeback_4d.sv
// Directed + random bench for mtsp_dst_writeback_4d with a scoreboard and float-rule reference model.
module tb_mtsp_dst_writeback_4d;

  typedef struct packed {
    logic [3:0]   we;
    logic [7:0]   addr;
    logic [127:0] dat;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cnt_clr;
  logic        busy;
  logic [15:0] clamp_cnt;

  mtsp_dst_writeback_4d_if #(.ADDR_W(8)) bus ();

  mtsp_dst_writeback_4d #(.ADDR_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .cnt_clr   (cnt_clr),
    .busy      (busy),
    .clamp_cnt (clamp_cnt)
  );

  always #5 clk = ~clk;

  int           total = 0;
  int           bad = 0;
  int           exp_cnt = 0;
  bit           acc_flag;
  bit           rand_rdy = 1'b0;
  bit           hold_v = 1'b0;
  logic [3:0]   hold_we;
  logic [7:0]   hold_addr;
  logic [127:0] hold_dat;
  beat_t        exp_q[$];
  logic [31:0]  specials [12] = '{32'h00000000, 32'h80000000, 32'h3F800000, 32'hBF800000,
                                  32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'h3F000000,
                                  32'h40000000, 32'hC0000000, 32'h3F800001, 32'hFFC00001};

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, expv);
      $error("check %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference: a float is NaN with all-ones exponent and nonzero fraction; "greater than one"
  // means its magnitude exceeds 1.0, which also covers infinities.
  function automatic logic [31:0] ref_lane(input logic [1:0] op, input logic [31:0] x);
`ifdef MTSP_DSTOP_SATURATE_EN
    bit is_nan = (x[30:23] == 8'hFF) && (x[22:0] != 0);
    bit is_big = (x[30:0] > 31'h3F800000);
    if (op == 2'b01) begin
      if (is_nan || x[31]) return 32'h0;
      if (is_big) return 32'h3F800000;
      return x;
    end
    if (op == 2'b10) begin
      if (is_nan) return 32'h0;
      if (is_big) return x[31] ? 32'hBF800000 : 32'h3F800000;
      return x;
    end
`else
    if (op == 2'b11) return x;
`endif
    return x;
  endfunction

  function automatic logic [127:0] ref_dat(input logic [1:0] op, input logic [127:0] d);
    logic [127:0] r;
    for (int i = 0; i < 4; i++) r[32*i +: 32] = ref_lane(op, d[32*i +: 32]);
    return r;
  endfunction

  function automatic bit ref_clamped(input logic [1:0] op, input logic [3:0] m, input logic [127:0] d);
    logic [127:0] r = ref_dat(op, d);
    for (int i = 0; i < 4; i++)
      if (m[i] && (r[32*i +: 32] != d[32*i +: 32])) return 1'b1;
    return 1'b0;
  endfunction

  // Inspect handshakes at the negedge before the edge that acts on them.
  task automatic cycle();
    beat_t b;
    @(negedge clk);
    acc_flag = 1'b0;
    if (hold_v) begin
      chk("stall_we", bus.out_we, hold_we);
      chk("stall_addr", bus.out_addr, hold_addr);
      chk("stall_dat", bus.out_dat, hold_dat);
    end
    hold_v    = bus.out_vld && !bus.out_rdy;
    hold_we   = bus.out_we;
    hold_addr = bus.out_addr;
    hold_dat  = bus.out_dat;
    if (bus.in_vld && bus.in_rdy) begin
      acc_flag = 1'b1;
      if (bus.in_mask != 4'b0000) begin
        b.we   = bus.in_mask;
        b.addr = bus.in_addr;
        b.dat  = ref_dat(bus.in_op, bus.in_dat);
        exp_q.push_back(b);
        if (ref_clamped(bus.in_op, bus.in_mask, bus.in_dat) && exp_cnt < 65535) exp_cnt++;
      end
    end
    if (bus.out_vld && bus.out_rdy) begin
      if (exp_q.size() == 0) begin
        chk("spurious_beat", bus.out_vld, 1'b0);
      end else begin
        b = exp_q.pop_front();
        chk("out_we", bus.out_we, b.we);
        chk("out_addr", bus.out_addr, b.addr);
        chk("out_dat", bus.out_dat, b.dat);
      end
    end
    @(posedge clk);
    #1;
    if (rand_rdy) bus.out_rdy = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [1:0] op, input logic [3:0] m, input logic [7:0] a, input logic [127:0] d);
    bus.in_vld  = 1'b1;
    bus.in_op   = op;
    bus.in_mask = m;
    bus.in_addr = a;
    bus.in_dat  = d;
    for (int n = 0; n < 64; n++) begin
      cycle();
      if (acc_flag) break;
    end
    if (!acc_flag) chk("send_timeout", acc_flag, 1'b1);
    bus.in_vld = 1'b0;
  endtask

  task automatic drain();
    bus.in_vld = 1'b0;
    rand_rdy   = 1'b0;
    bus.out_rdy = 1'b1;
    for (int n = 0; n < 200; n++) begin
      if (exp_q.size() == 0 && !busy) break;
      cycle();
    end
    chk("drain_busy", busy, 1'b0);
    chk("drain_left", exp_q.size(), 0);
  endtask

  function automatic logic [127:0] rand_dat();
    logic [127:0] d;
    for (int i = 0; i < 4; i++)
      d[32*i +: 32] = ($urandom_range(0, 1) != 0) ? specials[$urandom_range(0, 11)] : $urandom;
    return d;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] d, e;
    rst = 1'b1; cnt_clr = 1'b0;
    bus.in_vld = 1'b0; bus.in_op = 2'b00; bus.in_mask = 4'h0; bus.in_addr = 8'h0; bus.in_dat = '0;
    bus.out_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_vld", bus.out_vld, 1'b0);
    chk("rst_in_rdy", bus.in_rdy, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_we", bus.out_we, 4'h0);
    chk("rst_addr", bus.out_addr, 8'h0);
    chk("rst_dat", bus.out_dat, 128'h0);
    chk("rst_cnt", clamp_cnt, 16'h0);
    rst = 1'b0;
    cycle();

    // sat[0,1], full mask, one-cycle latency
    d = {32'h3E800000, 32'h7FC00000, 32'hBF000000, 32'h40000000};
`ifdef MTSP_DSTOP_SATURATE_EN
    e = {32'h3E800000, 32'h00000000, 32'h00000000, 32'h3F800000};
`else
    e = d;
`endif
    send(2'b01, 4'hF, 8'h05, d);
    chk("lat_not_yet", bus.out_vld, 1'b0);
    cycle();
    chk("lat_vld", bus.out_vld, 1'b1);
    chk("sat01_dat", bus.out_dat, e);
    drain();
    chk("cnt_sat01", clamp_cnt, exp_cnt);

    // sat[-1,1]
    d = {32'h3F800000, 32'h80000000, 32'h7F800000, 32'hC0400000};
`ifdef MTSP_DSTOP_SATURATE_EN
    e = {32'h3F800000, 32'h80000000, 32'h3F800000, 32'hBF800000};
`else
    e = d;
`endif
    send(2'b10, 4'hF, 8'h33, d);
    cycle();
    chk("satn11_dat", bus.out_dat, e);
    drain();
    chk("cnt_satn11", clamp_cnt, exp_cnt);

    // masking
    begin
      bit seen = 1'b0;
      send(2'b01, 4'h0, 8'h44, rand_dat());
      for (int n = 0; n < 4; n++) begin
        cycle();
        if (bus.out_vld) seen = 1'b1;
      end
      chk("mask0_no_out", seen, 1'b0);
    end
    send(2'b10, 4'b0101, 8'h12, rand_dat());
    cycle();
    chk("mask_we", bus.out_we, 4'b0101);
    chk("mask_addr", bus.out_addr, 8'h12);
    drain();

    // backpressure: two beats fill both stages, then stall
    bus.out_rdy = 1'b0;
    send(2'b01, 4'hF, 8'hA0, rand_dat());
    send(2'b10, 4'hF, 8'hA1, rand_dat());
    chk("bp_in_rdy_low", bus.in_rdy, 1'b0);
    chk("bp_busy", busy, 1'b1);
    cycle();
    cycle();
    bus.out_rdy = 1'b1;
    send(2'b00, 4'hF, 8'hA2, rand_dat());
    send(2'b11, 4'hF, 8'hA3, rand_dat());
    drain();

    // random traffic with random output stalls
    rand_rdy = 1'b1;
    for (int n = 0; n < 300; n++)
      send(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 8'($urandom), rand_dat());
    drain();
    chk("cnt_random", clamp_cnt, exp_cnt);

    // clear coinciding with a clamped beat entering stage B
    send(2'b01, 4'h1, 8'h00, {96'h0, 32'h40000000});
    cnt_clr = 1'b1;
    cycle();
    cnt_clr = 1'b0;
    exp_cnt = 0;
    chk("clr_wins", clamp_cnt, 16'h0);
    drain();

`ifdef MTSP_DSTOP_SATURATE_EN
    for (int n = 0; n < 65537; n++) send(2'b01, 4'h1, 8'h00, {96'h0, 32'h40000000});
    drain();
    chk("cnt_saturated", clamp_cnt, 16'hFFFF);
`endif

    // reset with two beats in flight
    bus.out_rdy = 1'b0;
    send(2'b01, 4'hF, 8'hB0, rand_dat());
    send(2'b01, 4'hF, 8'hB1, rand_dat());
    rst = 1'b1;
    #1;
    chk("midrst_out_vld", bus.out_vld, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    exp_q.delete();
    hold_v  = 1'b0;
    exp_cnt = 0;
    bus.out_rdy = 1'b1;
    cycle();
    rst = 1'b0;
    chk("postrst_in_rdy", bus.in_rdy, 1'b1);
    chk("postrst_cnt", clamp_cnt, 16'h0);
    send(2'b00, 4'hF, 8'hC0, rand_dat());
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mtsp_dst_writeback_4d.md
# mtsp_dst_writeback_4d

Destination-side counterpart of the 4-lane source-operand modifier. It takes 4×32-bit float results from the execution units and applies the destination modifier: none, saturate to [0,1] or saturate to [-1,1]. It then applies the per-lane write mask and presents a registered write beat to the register-file write port. It sits between the ALU result bus and the register file, in a 2-stage valid/ready pipeline with backpressure.

## Interface
- ADDR_W, 8, register-file address width
- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- IN_VALID  in  1  result beat valid
- IN_READY  out  1  beat accepted when IN_VALID & IN_READY at a CLK edge
- IN_OP  in  2  destination op: 00 none, 01 sat[0,1], 10 sat[-1,1], 11 reserved (treated as 00)
- IN_MASK  in  4  write mask, bit0=X … bit3=W
- IN_ADDR  in  ADDR_W  destination register
- IN_DATA  in  128  X=[31:0], Y=[63:32], Z=[95:64], W=[127:96]
- OUT_VALID  out  1  write beat valid
- OUT_READY  in  1  register file accepts the beat
- OUT_WE  out  4  per-lane write enable
- OUT_ADDR  out  ADDR_W  write address
- OUT_DATA  out  128  modified data
- BUSY  out  1  high when any beat is in flight
- CNT_CLR  in  1  synchronous clear of CLAMP_CNT
- CLAMP_CNT  out  16  saturating count of beats with at least one clamped enabled lane

## Operation
- Stage A (registered): captures op, mask, address and data. It also registers per-lane flags: nan, sign, mag_gt_one (|bits[30:0]| > 0x3F800000). NaN means exponent 0xFF with a non-zero mantissa.
- Stage B (registered, drives OUT_*): selects the result per lane.
  - sat[0,1]:
    - NaN → 0x00000000
    - sign set, including −0 → 0x00000000
    - mag_gt_one, including +inf → 0x3F800000
    - otherwise pass through
  - sat[-1,1]:
    - NaN → 0x00000000
    - mag_gt_one → {sign, 0x3F800000[30:0]}
    - otherwise pass through (−0 is kept)
  - none/reserved: pass through bit-exact.
- OUT_WE = captured mask. Masked-off lanes still carry the modified data, but the register file ignores them.
- A beat with IN_MASK=0000 is accepted and retired in stage A. It never appears on OUT_*.
- A beat counts as clamped when any enabled lane's output differs from its input. On each clamped beat entering stage B, CLAMP_CNT increments, saturating at 0xFFFF.
- If CNT_CLR coincides with an increment, the clear wins and CLAMP_CNT becomes 0.
- Beats are never reordered or duplicated.

## Timing
- Reset values: IN_READY=1 (combinational from empty stages), OUT_VALID=0, OUT_WE=0, OUT_ADDR=0, OUT_DATA=0, BUSY=0, CLAMP_CNT=0. Asserting RST mid-operation drops all in-flight beats immediately.
- Latency: a beat accepted at edge N is on OUT_* after edge N+1 when OUT_READY stays high. Sustained throughput is 1 beat/cycle.
- Stage ready signals:
  - b_adv = !OUT_VALID | OUT_READY
  - a_adv = !a_valid | b_adv
  - IN_READY = a_adv
- The combinational path OUT_READY → IN_READY is permitted.
- While OUT_VALID=1 and OUT_READY=0, OUT_* hold stable. With both stages full, IN_READY=0.
- BUSY = a_valid | OUT_VALID.
- Simultaneous accept and drain: full throughput with no bubble.

## Configuration
- MTSP_DSTOP_SATURATE_EN defined: saturation logic and CLAMP_CNT are as described above.
- Not defined:
  - IN_OP is ignored and all data passes bit-exact.
  - Stage A nan/sign/mag flags are not built.
  - CLAMP_CNT is tied to 0 and CNT_CLR is ignored.
  - Latency and handshake are unchanged.

## Structure
- Shared package mtsp_dst_pkg holds:
  - enum dstop_t {DSTOP_NONE, DSTOP_SAT01, DSTOP_SATN11, DSTOP_RSVD}
  - FP_ONE = 32'h3F800000
  - FP_NEG_ONE = 32'hBF800000
  - lane-flag struct {nan, sign, gt_one}
- One sub-module, mtsp_dst_operate_1d, instantiated 4×. It performs the per-lane flag classification and the clamp select, plus a clamped flag.

## Test plan
- Reset: hold RST=1 mid-stream with 2 beats in flight → OUT_VALID=0 and BUSY=0 immediately; after release, IN_READY=1 and CLAMP_CNT=0.
- sat[0,1] with IN_MASK=1111:
  - input X=0x40000000, Y=0xBF000000, Z=0x7FC00000, W=0x3E800000
  - → OUT_DATA lanes 0x3F800000, 0x00000000, 0x00000000, 0x3E800000 one cycle after accept
  - → CLAMP_CNT=1
- sat[-1,1]:
  - input X=0xC0400000, Y=0x7F800000, Z=0x80000000, W=0x3F800000
  - → 0xBF800000, 0x3F800000, 0x80000000, 0x3F800000
- Backpressure: 4 back-to-back beats with OUT_READY low for 3 cycles → IN_READY drops after 2 beats accepted; OUT_* stable; all 4 beats delivered in order, no loss or duplication.
- Masking:
  - IN_MASK=0000 → no OUT_VALID
  - IN_MASK=0101 at address 0x12 → OUT_WE=0101, OUT_ADDR=0x12
- Counter: after 65537 clamped beats, CLAMP_CNT=0xFFFF. CNT_CLR coinciding with a clamped beat → CLAMP_CNT=0.
